// File: rtl/pwl_pkg.sv
// Shared types and helpers for the programmable piecewise-linear activation unit.
package pwl_pkg;

  localparam int unsigned PWL_DATA_W = 16;
  localparam int unsigned PWL_FRAC_W = 9;
  localparam int unsigned PWL_NSEG   = 32;
  localparam int unsigned PWL_SH_W   = 4;

  typedef enum logic [1:0] {
    CFG_BP   = 2'd0,
    CFG_X0   = 2'd1,
    CFG_BIAS = 2'd2,
    CFG_SHZ  = 2'd3
  } cfg_field_e;

  // Per-segment evaluation fields; the breakpoint lives in a separate table.
  typedef struct packed {
    logic [PWL_DATA_W-1:0] x0;
    logic [PWL_DATA_W-1:0] bias;
    logic [PWL_SH_W-1:0]   shift;
    logic                  zero;
  } seg_entry_t;

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pwl_seg_select.sv
// Segment lookup: thermometer compare of x against breakpoints 1..NSEG-1, then popcount.
module pwl_seg_select #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NSEG   = 32
) (
  input  logic signed [DATA_W-1:0]       x,
  input  logic        [DATA_W-1:0]       bp [1:NSEG-1],
  output logic        [$clog2(NSEG)-1:0] seg
);

  localparam int unsigned SEG_W = $clog2(NSEG);

  logic [NSEG-1:1] ge;

  for (genvar k = 1; k < NSEG; k++) begin : g_cmp
    assign ge[k] = (x >= $signed(bp[k]));
  end

  // Count of breakpoints at or below x; at most NSEG-1 so it fits SEG_W bits.
  always_comb begin
    seg = '0;
    for (int unsigned k = 1; k < NSEG; k++) begin
      seg = seg + SEG_W'(ge[k]);
    end
  end

endmodule

// File: rtl/pwl_activation.sv
// Programmable piecewise-linear activation: run-time segment table, 3-stage valid/ready pipeline.
module pwl_activation
  import pwl_pkg::*;
#(
  parameter int unsigned DATA_W = PWL_DATA_W,
  parameter int unsigned NSEG   = PWL_NSEG,
  parameter int unsigned SH_W   = PWL_SH_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_y,
  input  logic                      cfg_we,
  input  logic [$clog2(NSEG)-1:0]   cfg_addr,
  input  logic [1:0]                cfg_field,
  input  logic [DATA_W-1:0]         cfg_data
);

  localparam int unsigned SEG_W = $clog2(NSEG);
  localparam int unsigned DW1   = DATA_W + 1;
  localparam int unsigned DW2   = DATA_W + 2;

  logic [DATA_W-1:0] bp_q  [1:NSEG-1];
  seg_entry_t        ent_q [NSEG];
  logic [SEG_W-1:0]  seg_c;
  logic              adv;

  logic                     v1, v2;
  logic signed [DATA_W-1:0] x1;
  seg_entry_t               e1;
  logic signed [DATA_W:0]   d2;
  logic signed [DATA_W-1:0] b2;
  logic                     z2;

  logic signed [DATA_W:0]   diff_c;
  logic signed [DATA_W:0]   shifted_c;
  logic signed [DATA_W+1:0] sum_c;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Table writes are never blocked; S1 reads the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 1; k < NSEG; k++) bp_q[k] <= '0;
      for (int unsigned k = 0; k < NSEG; k++) ent_q[k] <= '0;
    end else if (cfg_we) begin
      case (cfg_field_e'(cfg_field))
        CFG_BP:   if (cfg_addr != '0) bp_q[cfg_addr] <= cfg_data;
        CFG_X0:   ent_q[cfg_addr].x0   <= cfg_data;
        CFG_BIAS: ent_q[cfg_addr].bias <= cfg_data;
        CFG_SHZ: begin
          ent_q[cfg_addr].shift <= cfg_data[SH_W-1:0];
          ent_q[cfg_addr].zero  <= cfg_data[SH_W];
        end
        default: ;
      endcase
    end
  end

  pwl_seg_select #(
    .DATA_W (DATA_W),
    .NSEG   (NSEG)
  ) u_seg_select (
    .x   (in_x),
    .bp  (bp_q),
    .seg (seg_c)
  );

  always_comb begin
    diff_c    = DW1'(x1) - DW1'($signed(e1.x0));
    shifted_c = diff_c >>> e1.shift;
    sum_c     = DW2'(d2) + DW2'(b2);
  end

  // All stages advance together; bubbles travel with their slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      e1        <= '0;
      d2        <= '0;
      b2        <= '0;
      z2        <= 1'b0;
      out_y     <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      x1        <= in_x;
      e1        <= ent_q[seg_c];
      v2        <= v1;
      d2        <= shifted_c;
      b2        <= $signed(e1.bias);
      z2        <= e1.zero;
      out_valid <= v2;
      out_y     <= z2 ? '0 : DATA_W'(sat(64'(sum_c), DATA_W));
    end
  end

endmodule
